// File: rtl/spectag_tracker_if.sv
// Dispatch/resolution bus between the speculative-tag generator side and spectag_tracker.
// master drives dispatch and resolution inputs; slave is the tracker.
interface spectag_tracker_if #(
  parameter int SPECTAG_LEN = 5,
  parameter int CNT_LEN     = 3
);
  logic                   enable;
  logic                   branchvalid1;
  logic                   branchvalid2;
  logic [SPECTAG_LEN-1:0] sptag1;
  logic [SPECTAG_LEN-1:0] sptag2;
  logic                   prmiss;
  logic                   prsuccess;
  logic [SPECTAG_LEN-1:0] prtag;
  logic [SPECTAG_LEN-1:0] tagregfix;
  logic [SPECTAG_LEN-1:0] killmask;
  logic [SPECTAG_LEN-1:0] validmask;
  logic [SPECTAG_LEN-1:0] oldesttag;
  logic [CNT_LEN-1:0]     brcount;
  logic                   err;

  modport master (
    output enable, branchvalid1, branchvalid2, sptag1, sptag2,
           prmiss, prsuccess, prtag,
    input  tagregfix, killmask, validmask, oldesttag, brcount, err
  );

  modport slave (
    input  enable, branchvalid1, branchvalid2, sptag1, sptag2,
           prmiss, prsuccess, prtag,
    output tagregfix, killmask, validmask, oldesttag, brcount, err
  );
endinterface

// File: rtl/spectag_tracker.sv
// Tracks live one-hot speculative branch tags and the oldest outstanding branch.
// Optional protocol checker enabled by defining SPECTAG_TRACKER_CHECK_EN.
module spectag_tracker #(
  parameter int SPECTAG_LEN = 5,
  parameter int CNT_LEN     = 3
) (
  input  logic              clk,
  input  logic              reset,
  spectag_tracker_if.slave  bus
);

  logic [SPECTAG_LEN-1:0] r_validmask;
  logic [SPECTAG_LEN-1:0] r_oldesttag;
  logic [CNT_LEN-1:0]     r_brcount;

  logic                   w_alloc;
  logic                   w_resolve;
  logic [SPECTAG_LEN-1:0] w_set;
  logic [SPECTAG_LEN-1:0] w_clr;
  logic [SPECTAG_LEN-1:0] w_valid_next;
  logic [SPECTAG_LEN-1:0] w_oldest_next;
  logic [SPECTAG_LEN-1:0] w_prtag_rot;
  logic [CNT_LEN-1:0]     w_count_next;

  assign w_alloc     = bus.enable & ~bus.prmiss;
  assign w_resolve   = bus.prmiss | bus.prsuccess;
  assign w_prtag_rot = {bus.prtag[SPECTAG_LEN-2:0], bus.prtag[SPECTAG_LEN-1]};

  always_comb begin
    w_set = '0;
    if (w_alloc && bus.branchvalid1) w_set = w_set | bus.sptag1;
    if (w_alloc && bus.branchvalid2) w_set = w_set | bus.sptag2;
    w_clr = (bus.prsuccess && !bus.prmiss) ? bus.prtag : '0;
    w_valid_next = bus.prmiss ? '0 : ((r_validmask & ~w_clr) | w_set);
  end

  // Any resolution advances the oldest pointer; otherwise only the first branch into an empty machine moves it.
  always_comb begin
    w_oldest_next = r_oldesttag;
    if (w_resolve)
      w_oldest_next = w_prtag_rot;
    else if (w_alloc && (r_validmask == '0) && bus.branchvalid1)
      w_oldest_next = bus.sptag1;
    else if (w_alloc && (r_validmask == '0) && bus.branchvalid2)
      w_oldest_next = bus.sptag2;
  end

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < SPECTAG_LEN; i++)
      w_count_next = w_count_next + CNT_LEN'(w_valid_next[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_validmask <= '0;
      r_oldesttag <= SPECTAG_LEN'(1);
      r_brcount   <= '0;
    end else begin
      r_validmask <= w_valid_next;
      r_oldesttag <= w_oldest_next;
      r_brcount   <= w_count_next;
    end
  end

  assign bus.validmask = r_validmask;
  assign bus.oldesttag = r_oldesttag;
  assign bus.brcount   = r_brcount;
  assign bus.tagregfix = bus.prmiss ? bus.prtag : r_oldesttag;
  assign bus.killmask  = bus.prmiss ? (r_validmask & ~bus.prtag) : '0;

`ifdef SPECTAG_TRACKER_CHECK_EN
  logic r_err;
  logic w_viol;
  logic w_prtag_onehot;

  assign w_prtag_onehot = (bus.prtag != '0) &&
                          ((bus.prtag & (bus.prtag - SPECTAG_LEN'(1))) == '0);

  always_comb begin
    w_viol = 1'b0;
    if (w_alloc && ((w_set & r_validmask) != '0)) w_viol = 1'b1;
    if (w_alloc && bus.branchvalid1 && bus.branchvalid2 && (bus.sptag1 == bus.sptag2))
      w_viol = 1'b1;
    if (w_resolve && ((bus.prtag != r_oldesttag) || (r_validmask == '0) || !w_prtag_onehot))
      w_viol = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)       r_err <= 1'b0;
    else if (w_viol) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_spectag_tracker.sv
// Directed vector bench for spectag_tracker; err expectations follow SPECTAG_TRACKER_CHECK_EN.
module tb_spectag_tracker;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  spectag_tracker_if #(.SPECTAG_LEN(5), .CNT_LEN(3)) bus ();

  spectag_tracker #(.SPECTAG_LEN(5), .CNT_LEN(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       bv1;
    logic       bv2;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       miss;
    logic       succ;
    logic [4:0] prtag;
    logic [4:0] exp_fix;
    logic [4:0] exp_kill;
    logic [4:0] exp_valid;
    logic [4:0] exp_old;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs [16];

`ifdef SPECTAG_TRACKER_CHECK_EN
  localparam logic EXP_ERR_BAD = 1'b1;
`else
  localparam logic EXP_ERR_BAD = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.enable = 0; bus.branchvalid1 = 0; bus.branchvalid2 = 0;
    bus.sptag1 = '0; bus.sptag2 = '0;
    bus.prmiss = 0; bus.prsuccess = 0; bus.prtag = '0;
  endtask

  task automatic check_state(input string tag, input logic [4:0] v, input logic [4:0] o,
                             input logic [2:0] c, input logic e);
    check({tag, ".validmask"}, 32'(bus.validmask), 32'(v));
    check({tag, ".oldesttag"}, 32'(bus.oldesttag), 32'(o));
    check({tag, ".brcount"},   32'(bus.brcount),   32'(c));
    check({tag, ".err"},       32'(bus.err),       32'(e));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive_idle();
    reset = 1'b1;

    //            en bv1 bv2 s1       s2       miss succ prtag    fix      kill     valid    old      cnt
    vecs[0]  = '{0, 0, 0, 5'b00000, 5'b00000, 0, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00001, 3'd0};
    vecs[1]  = '{1, 1, 1, 5'b00001, 5'b00010, 0, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00011, 5'b00001, 3'd2};
    vecs[2]  = '{1, 1, 0, 5'b00100, 5'b00000, 0, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00111, 5'b00001, 3'd3};
    vecs[3]  = '{1, 1, 0, 5'b01000, 5'b00000, 0, 1, 5'b00001, 5'b00001, 5'b00000, 5'b01110, 5'b00010, 3'd3};
    vecs[4]  = '{1, 1, 0, 5'b10000, 5'b00000, 1, 0, 5'b00010, 5'b00010, 5'b01100, 5'b00000, 5'b00100, 3'd0};
    vecs[5]  = '{1, 1, 0, 5'b00100, 5'b00000, 0, 0, 5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00100, 3'd1};
    vecs[6]  = '{1, 0, 1, 5'b00000, 5'b01000, 0, 0, 5'b00000, 5'b00100, 5'b00000, 5'b01100, 5'b00100, 3'd2};
    vecs[7]  = '{0, 0, 0, 5'b00000, 5'b00000, 0, 1, 5'b00100, 5'b00100, 5'b00000, 5'b01000, 5'b01000, 3'd1};
    vecs[8]  = '{1, 1, 0, 5'b10000, 5'b00000, 0, 1, 5'b01000, 5'b01000, 5'b00000, 5'b10000, 5'b10000, 3'd1};
    vecs[9]  = '{1, 1, 0, 5'b00001, 5'b00000, 0, 0, 5'b00000, 5'b10000, 5'b00000, 5'b10001, 5'b10000, 3'd2};
    vecs[10] = '{0, 0, 0, 5'b00000, 5'b00000, 0, 1, 5'b10000, 5'b10000, 5'b00000, 5'b00001, 5'b00001, 3'd1};
    vecs[11] = '{1, 1, 1, 5'b00010, 5'b00100, 0, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00111, 5'b00001, 3'd3};
    vecs[12] = '{1, 1, 1, 5'b01000, 5'b10000, 0, 0, 5'b00000, 5'b00001, 5'b00000, 5'b11111, 5'b00001, 3'd5};
    vecs[13] = '{0, 0, 0, 5'b00000, 5'b00000, 1, 1, 5'b00001, 5'b00001, 5'b11110, 5'b00000, 5'b00010, 3'd0};
    vecs[14] = '{1, 0, 1, 5'b00000, 5'b00010, 0, 0, 5'b00000, 5'b00010, 5'b00000, 5'b00010, 5'b00010, 3'd1};
    vecs[15] = '{0, 1, 0, 5'b00100, 5'b00000, 0, 0, 5'b00000, 5'b00010, 5'b00000, 5'b00010, 5'b00010, 3'd1};

    // Reset then three idle cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset", 5'b00000, 5'b00001, 3'd0, 1'b0);
    check("reset.killmask",  32'(bus.killmask),  32'd0);
    check("reset.tagregfix", 32'(bus.tagregfix), 32'd1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.enable = vecs[i].en;       bus.branchvalid1 = vecs[i].bv1;
      bus.branchvalid2 = vecs[i].bv2; bus.sptag1 = vecs[i].s1;
      bus.sptag2 = vecs[i].s2;       bus.prmiss = vecs[i].miss;
      bus.prsuccess = vecs[i].succ;  bus.prtag = vecs[i].prtag;
      #1;
      check($sformatf("v%0d.tagregfix", i), 32'(bus.tagregfix), 32'(vecs[i].exp_fix));
      check($sformatf("v%0d.killmask", i),  32'(bus.killmask),  32'(vecs[i].exp_kill));
      @(posedge clk);
      #1;
      check_state($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_old, vecs[i].exp_cnt, 1'b0);
    end

    // Reset mid-operation overrides a same-cycle allocation
    @(negedge clk);
    drive_idle();
    bus.enable = 1; bus.branchvalid1 = 1; bus.sptag1 = 5'b00100;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state("midreset", 5'b00000, 5'b00001, 3'd0, 1'b0);

    // Out-of-order resolution on an empty machine: err sticky only with checker built in
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    bus.prsuccess = 1; bus.prtag = 5'b00100;
    @(posedge clk);
    #1;
    check_state("badres", 5'b00000, 5'b01000, 3'd0, EXP_ERR_BAD);
    @(negedge clk);
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("badres.sticky", 32'(bus.err), 32'(EXP_ERR_BAD));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("badres.cleared", 32'(bus.err), 32'd0);

    // Duplicate allocation of a live tag
    @(negedge clk);
    reset = 1'b0;
    bus.enable = 1; bus.branchvalid1 = 1; bus.sptag1 = 5'b00001;
    @(posedge clk);
    #1;
    check("alloc.err", 32'(bus.err), 32'd0);
    @(negedge clk);
    bus.sptag1 = 5'b00001;
    @(posedge clk);
    #1;
    check_state("overflow", 5'b00001, 5'b00001, 3'd1, EXP_ERR_BAD);

    @(negedge clk);
    drive_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
